// File: rtl/ppmem_pkg.sv
// Shared geometry and types for the asymmetric pulse-program memory.
// The memory is 16384 x 16 bits on the host port and 4096 x 64 bits on the sequencer port.
package ppmem_pkg;

    localparam int PPMEM_A_AW  = 14;
    localparam int PPMEM_A_DW  = 16;
    localparam int PPMEM_B_AW  = 12;
    localparam int PPMEM_B_DW  = 64;
    localparam int PPMEM_LANES = 4;

    typedef logic [PPMEM_A_AW-1:0] ppmem_a_addr_t;
    typedef logic [PPMEM_A_DW-1:0] ppmem_a_data_t;
    typedef logic [PPMEM_B_AW-1:0] ppmem_b_addr_t;
    typedef logic [PPMEM_B_DW-1:0] ppmem_b_data_t;

endpackage

// File: rtl/ppmem_lane.sv
// One 16-bit lane bank: single-clock true dual-port RAM.
// Both ports are read-first, and port A wins a same-address write collision.
module ppmem_lane
    import ppmem_pkg::*;
#(
    parameter int AW = PPMEM_B_AW,
    parameter int DW = PPMEM_A_DW
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_wea,
    input  logic [AW-1:0] i_addra,
    input  logic [DW-1:0] i_dina,
    output logic [DW-1:0] o_qa,
    input  logic          i_web,
    input  logic [AW-1:0] i_addrb,
    input  logic [DW-1:0] i_dinb,
    output logic [DW-1:0] o_qb
);

    logic [DW-1:0] r_mem [2**AW];
    logic [DW-1:0] r_qa;
    logic [DW-1:0] r_qb;

    // Port A write comes second so it overrides port B on the same address.
    always_ff @(posedge i_clk) begin
        if (i_web) r_mem[i_addrb] <= i_dinb;
        if (i_wea) r_mem[i_addra] <= i_dina;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_qa <= '0;
            r_qb <= '0;
        end else begin
            r_qa <= r_mem[i_addra];
            r_qb <= r_mem[i_addrb];
        end
    end

    assign o_qa = r_qa;
    assign o_qb = r_qb;

endmodule

// File: rtl/ppmem_asym.sv
// Asymmetric dual-port pulse-program memory: 16-bit port A over four 16-bit lane banks, 64-bit port B.
// Defining PPMEM_OUTREG_EN adds an output register on both ports, giving a read latency of 2.
module ppmem_asym
    import ppmem_pkg::*;
#(
    parameter int A_AW = PPMEM_A_AW,
    parameter int A_DW = PPMEM_A_DW,
    parameter int B_AW = PPMEM_B_AW,
    parameter int B_DW = PPMEM_B_DW
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wea,
    input  logic [A_AW-1:0] addra,
    input  logic [A_DW-1:0] dina,
    output logic [A_DW-1:0] douta,
    input  logic            web,
    input  logic [B_AW-1:0] addrb,
    input  logic [B_DW-1:0] dinb,
    output logic [B_DW-1:0] doutb
);

    logic [PPMEM_LANES-1:0] w_wea_lane;
    logic [A_DW-1:0]        w_qa [PPMEM_LANES];
    logic [B_DW-1:0]        w_qb;
    logic [A_DW-1:0]        w_douta;
    logic [1:0]             r_lane_sel;

    always_comb begin
        w_wea_lane = '0;
        w_wea_lane[addra[1:0]] = wea;
    end

    for (genvar g = 0; g < PPMEM_LANES; g++) begin : g_lane
        ppmem_lane #(
            .AW(B_AW),
            .DW(A_DW)
        ) u_lane (
            .i_clk   (clk),
            .i_rst_n (rst_n),
            .i_wea   (w_wea_lane[g]),
            .i_addra (addra[A_AW-1:2]),
            .i_dina  (dina),
            .o_qa    (w_qa[g]),
            .i_web   (web),
            .i_addrb (addrb),
            .i_dinb  (dinb[g*A_DW +: A_DW]),
            .o_qb    (w_qb[g*A_DW +: A_DW])
        );
    end

    // Lane select is registered so that it lines up with the bank's registered read data.
    always_ff @(posedge clk) begin
        if (!rst_n) r_lane_sel <= '0;
        else        r_lane_sel <= addra[1:0];
    end

    assign w_douta = w_qa[r_lane_sel];

`ifdef PPMEM_OUTREG_EN
    logic [A_DW-1:0] r_douta;
    logic [B_DW-1:0] r_doutb;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_douta <= '0;
            r_doutb <= '0;
        end else begin
            r_douta <= w_douta;
            r_doutb <= w_qb;
        end
    end

    assign douta = r_douta;
    assign doutb = r_doutb;
`else
    assign douta = w_douta;
    assign doutb = w_qb;
`endif

endmodule

// File: tb/tb_ppmem_asym.sv
// Scoreboard bench for ppmem_asym: expected read data is queued when an access is driven
// and compared when it is due at the port output.
module tb_ppmem_asym;
    import ppmem_pkg::*;

`ifdef PPMEM_OUTREG_EN
    localparam int unsigned LAT = 2;
`else
    localparam int unsigned LAT = 1;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wea;
    ppmem_a_addr_t addra;
    ppmem_a_data_t dina;
    ppmem_a_data_t douta;
    logic          web;
    ppmem_b_addr_t addrb;
    ppmem_b_data_t dinb;
    ppmem_b_data_t doutb;

    always #5 clk = ~clk;

    ppmem_asym #(
        .A_AW(14),
        .A_DW(16),
        .B_AW(12),
        .B_DW(64)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .wea   (wea),
        .addra (addra),
        .dina  (dina),
        .douta (douta),
        .web   (web),
        .addrb (addrb),
        .dinb  (dinb),
        .doutb (doutb)
    );

    typedef struct {
        int unsigned due;
        bit          isb;
        logic [63:0] exp;
        string       tag;
    } sb_t;

    sb_t         sb[$];
    logic [15:0] mdl [16384];
    bit          vld [16384];
    int unsigned ncyc  = 0;
    int          total = 0;
    int          bad   = 0;

    // One clock cycle: drive the ports, queue expected reads (old data), update the model, check what is due.
    task automatic step(input bit rstv, input bit wa, input logic [13:0] aa, input logic [15:0] da,
                        input bit wb, input logic [11:0] ab, input logic [63:0] db,
                        input bit ca, input bit cb, input string tag);
        sb_t e;
        bit  okb;
        rst_n = rstv; wea = wa; addra = aa; dina = da; web = wb; addrb = ab; dinb = db;
        if (ca && vld[aa]) begin
            e.due = ncyc + LAT; e.isb = 1'b0; e.exp = {48'd0, mdl[aa]}; e.tag = {tag, "_a"};
            sb.push_back(e);
        end
        okb = 1'b1;
        for (int unsigned l = 0; l < 4; l++) okb &= vld[{ab, 2'(l)}];
        if (cb && okb) begin
            e.due = ncyc + LAT; e.isb = 1'b1;
            e.exp = {mdl[{ab, 2'd3}], mdl[{ab, 2'd2}], mdl[{ab, 2'd1}], mdl[{ab, 2'd0}]};
            e.tag = {tag, "_b"};
            sb.push_back(e);
        end
        if (wb) begin
            for (int unsigned l = 0; l < 4; l++) begin
                mdl[{ab, 2'(l)}] = db[16*l +: 16];
                vld[{ab, 2'(l)}] = 1'b1;
            end
        end
        if (wa) begin
            mdl[aa] = da;
            vld[aa] = 1'b1;
        end
        @(posedge clk);
        #1;
        ncyc++;
        while (sb.size() > 0 && sb[0].due <= ncyc) begin
            e = sb.pop_front();
            total++;
            if (e.due != ncyc) begin
                bad++;
                $display("FAIL %s: check missed, due=%0d now=%0d", e.tag, e.due, ncyc);
            end else if (e.isb && doutb !== e.exp) begin
                bad++;
                $display("FAIL %s: doutb got=%h exp=%h", e.tag, doutb, e.exp);
            end else if (!e.isb && {48'd0, douta} !== e.exp) begin
                bad++;
                $display("FAIL %s: douta got=%h exp=%h", e.tag, douta, e.exp[15:0]);
            end
        end
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) step(1, 0, '0, '0, 0, '0, '0, 0, 0, "idle");
    endtask

    task automatic check_zero(input string tag);
        total++;
        if (douta !== 16'h0 || doutb !== 64'h0) begin
            bad++;
            $display("FAIL %s: douta=%h doutb=%h exp=0/0", tag, douta, doutb);
        end
    endtask

    task automatic test_reset();
        step(0, 0, '0, '0, 0, '0, '0, 0, 0, "rst");
        check_zero("reset_1");
        step(0, 0, '0, '0, 0, '0, '0, 0, 0, "rst");
        check_zero("reset_2");
        idle(1);
    endtask

    task automatic test_a_write_b_read();
        step(1, 1, 14'd0, 16'h0123, 0, '0, '0, 0, 0, "a_wr0");
        step(1, 1, 14'd1, 16'h4567, 0, '0, '0, 0, 0, "a_wr1");
        step(1, 1, 14'd2, 16'h89AB, 0, '0, '0, 0, 0, "a_wr2");
        step(1, 1, 14'd3, 16'hCDEF, 0, '0, '0, 0, 0, "a_wr3");
        step(1, 0, 14'd2, '0, 0, 12'd0, '0, 1, 1, "b_rd0");
        idle(LAT);
    endtask

    task automatic test_b_write_a_read();
        step(1, 0, '0, '0, 1, 12'd4095, 64'h1111_2222_3333_4444, 0, 0, "b_wr4095");
        for (int unsigned i = 0; i < 4; i++)
            step(1, 0, 14'(16380 + i), '0, 0, 12'd4095, '0, 1, i == 0, $sformatf("a_rd%0d", 16380 + i));
        idle(LAT);
    endtask

    task automatic test_collision();
        step(1, 1, 14'd5, 16'hBEEF, 1, 12'd1, 64'hAAAA_BBBB_CCCC_DDDD, 0, 0, "coll_wr");
        step(1, 0, 14'd5, '0, 0, 12'd1, '0, 1, 1, "coll_rd");
        // Both ports write lane 0 of B word 7: port A must win.
        step(1, 1, 14'd28, 16'h1234, 1, 12'd7, 64'h9999_8888_7777_6666, 0, 0, "coll2_wr");
        step(1, 0, 14'd28, '0, 0, 12'd7, '0, 1, 1, "coll2_rd");
        idle(LAT);
    endtask

    task automatic test_read_first();
        step(1, 0, '0, '0, 1, 12'd2, 64'h0, 0, 0, "rf_clr");
        step(1, 1, 14'd8, 16'h5A5A, 0, 12'd2, '0, 0, 1, "rf_cross");
        step(1, 0, 14'd8, '0, 0, 12'd2, '0, 1, 1, "rf_new");
        // Each port writing and reading its own address returns the old word.
        step(1, 1, 14'd8, 16'hA5A5, 1, 12'd1, 64'h0F0F_0F0F_0F0F_0F0F, 1, 1, "rf_self");
        step(1, 0, 14'd8, '0, 0, 12'd1, '0, 1, 1, "rf_self_new");
        idle(LAT);
    endtask

    task automatic test_back_to_back();
        for (int unsigned i = 0; i < 300; i++) begin
            step(1, 1'($urandom_range(0, 1)), 14'(64 + $urandom_range(0, 63)), 16'($urandom),
                 1'($urandom_range(0, 2) == 0), 12'(16 + $urandom_range(0, 15)), {$urandom, $urandom},
                 1, 1, "b2b");
        end
        idle(LAT);
    endtask

    task automatic test_reset_retain();
        // Write presented during reset must still land.
        step(0, 1, 14'd40, 16'h7777, 0, '0, '0, 0, 0, "rst_wr");
        check_zero("reset_mid");
        step(1, 0, 14'd0, '0, 0, 12'd0, '0, 1, 1, "retain0");
        step(1, 0, 14'd40, '0, 0, 12'd10, '0, 1, 0, "retain40");
        idle(LAT);
    endtask

    initial begin
        for (int unsigned i = 0; i < 16384; i++) vld[i] = 1'b0;
        test_reset();
        test_a_write_b_read();
        test_b_write_a_read();
        test_collision();
        test_read_first();
        test_back_to_back();
        test_reset_retain();
        idle(2);
        while (sb.size() > 0) begin
            void'(sb.pop_front());
            total++;
            bad++;
            $display("FAIL leftover: scoreboard entry never checked, got=none exp=checked");
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
